// File: rtl/mem_miss_sequencer.sv
// Miss sequencer arbitrating I-fills, D read/write misses and dirty evictions onto one memory port.
// Optional: define MEM_MISS_WRITE_ALLOCATE_EN to fetch the line before merging a D write miss.
module mem_miss_sequencer #(
    parameter int ADDR_W  = 16,
    parameter bit D_FIRST = 1'b1,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_re,
    input  logic              d_we,
    input  logic              d_hit,
    input  logic              d_dirty,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_victim_addr,
    input  logic              mem_rdy,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              d_wr_we,
    output logic              d_set_dirty,
    output logic              i_done,
    output logic              d_done,
    output logic              err,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_FILL  = 3'd1,
        D_EVICT = 3'd2,
        D_FILL  = 3'd3,
        D_WRITE = 3'd4
    } state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

`ifdef MEM_MISS_WRITE_ALLOCATE_EN
    localparam state_t WR_MISS_STATE = D_FILL;
`else
    localparam state_t WR_MISS_STATE = D_WRITE;
`endif

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [ADDR_W-1:0]   d_addr_reg;
    logic                d_write_reg;

    logic d_miss;
    logic i_wins;
    logic d_wins;
    logic wait_state;
    logic timeout_hit;

    assign d_miss      = (d_re | d_we) & ~d_hit;
    assign i_wins      = i_miss & ~(d_miss & D_FIRST);
    assign d_wins      = d_miss & ~i_wins;
    assign wait_state  = (state_reg == I_FILL) | (state_reg == D_EVICT) | (state_reg == D_FILL);
    assign timeout_hit = (TIMEOUT != 0) && wait_state && !mem_rdy && (cnt_reg == CNT_LAST);
    assign mem_addr    = mem_addr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_wins) begin
                    state_next = I_FILL;
                end else if (d_wins) begin
                    if (d_dirty)   state_next = D_EVICT;
                    else if (d_re) state_next = D_FILL;
                    else           state_next = WR_MISS_STATE;
                end
            end
            I_FILL: begin
                if (mem_rdy || timeout_hit) state_next = IDLE;
            end
            D_EVICT: begin
                if (mem_rdy)          state_next = d_write_reg ? WR_MISS_STATE : D_FILL;
                else if (timeout_hit) state_next = IDLE;
            end
            D_FILL: begin
                if (mem_rdy)          state_next = d_write_reg ? D_WRITE : IDLE;
                else if (timeout_hit) state_next = IDLE;
            end
            D_WRITE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter restarts on every state change so each request phase gets a full timeout window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            mem_addr_reg <= '0;
            d_addr_reg   <= '0;
            d_write_reg  <= 1'b0;
        end else begin
            if (state_next != state_reg) begin
                cnt_reg <= '0;
            end else if (wait_state) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            if (state_reg == IDLE) begin
                if (i_wins) begin
                    mem_addr_reg <= i_addr;
                end else if (d_wins) begin
                    mem_addr_reg <= d_dirty ? d_victim_addr : d_addr;
                    d_addr_reg   <= d_addr;
                    d_write_reg  <= ~d_re;
                end
            end else if (state_reg == D_EVICT && mem_rdy) begin
                mem_addr_reg <= d_addr_reg;
            end
        end
    end

    always_comb begin
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        d_wr_we     = 1'b0;
        d_set_dirty = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        err         = timeout_hit;
        busy        = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                if (d_we && d_hit) begin
                    d_wr_we     = 1'b1;
                    d_set_dirty = 1'b1;
                end
            end
            I_FILL: begin
                mem_re    = 1'b1;
                i_fill_we = mem_rdy;
                i_done    = mem_rdy;
            end
            D_EVICT: begin
                mem_we = 1'b1;
            end
            D_FILL: begin
                mem_re    = 1'b1;
                d_fill_we = mem_rdy;
                d_done    = mem_rdy & ~d_write_reg;
            end
            D_WRITE: begin
                d_wr_we     = 1'b1;
                d_set_dirty = 1'b1;
                d_done      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
